scc_dmem_responder: RTL and testbench

//  Memory-side responder for the scc core data port: accepts core read/write requests,

---
 rtl/scc_dmem_responder_pkg.sv | 38 +++
 rtl/scc_dmem_responder_if.sv | 34 +++
 rtl/scc_dmem_responder_array.sv | 25 ++
 rtl/scc_dmem_responder.sv | 147 ++++++++++++++
 tb/tb_scc_dmem_responder.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/scc_dmem_responder_pkg.sv
// Shared types for the scc data-memory responder: FSM state encoding,
// completion status codes and the request legality check.
package scc_dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_RESP   = 2'd2,
        ST_HALTED = 2'd3
    } dmem_state_e;

    typedef enum logic [1:0] {
        MEM_ERR_OK    = 2'd0,
        MEM_ERR_BOTH  = 2'd1,
        MEM_ERR_ALIGN = 2'd2,
        MEM_ERR_RANGE = 2'd3
    } mem_err_e;

    // Earlier checks win: conflicting op, then alignment, then range.
    function automatic mem_err_e classify_req(
        input logic        rd,
        input logic        wr,
        input logic [31:0] addr,
        input int unsigned depth
    );
        mem_err_e result;
        result = MEM_ERR_OK;
        if (rd && wr) begin
            result = MEM_ERR_BOTH;
        end else if (addr[1:0] != 2'b00) begin
            result = MEM_ERR_ALIGN;
        end else if ({2'b00, addr[31:2]} >= depth) begin
            result = MEM_ERR_RANGE;
        end
        return result;
    endfunction

endpackage

// File: rtl/scc_dmem_responder_if.sv
// Core <-> responder data port. The core drives the request side (master),
// the responder returns data, ready and status (slave).
interface scc_dmem_responder_if;
    import scc_dmem_responder_pkg::*;

    logic [31:0] data_memory_a;
    logic        data_memory_read;
    logic        data_memory_write;
    logic [31:0] data_memory_out_v;
    logic [31:0] data_memory_in_v;
    logic        mem_ready;
    mem_err_e    mem_err;

    modport master (
        output data_memory_a,
        output data_memory_read,
        output data_memory_write,
        output data_memory_out_v,
        input  data_memory_in_v,
        input  mem_ready,
        input  mem_err
    );

    modport slave (
        input  data_memory_a,
        input  data_memory_read,
        input  data_memory_write,
        input  data_memory_out_v,
        output data_memory_in_v,
        output mem_ready,
        output mem_err
    );

endinterface

// File: rtl/scc_dmem_responder_array.sv
// DEPTH x 32-bit word storage: synchronous write, combinational read.
// Contents are deliberately never reset.
module scc_dmem_responder_array #(
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/scc_dmem_responder.sv
// Multi-cycle data-memory responder for the scc core: validates a request,
// waits WAIT_CYCLES enabled cycles, then completes it with a one-cycle ready.
module scc_dmem_responder
    import scc_dmem_responder_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_en,
    input  logic                 halt_f,
    scc_dmem_responder_if.slave  mem
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    dmem_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             is_write_q, is_write_d;
    mem_err_e         status_q, status_d;
    logic             halt_pend_q, halt_pend_d;
    logic [31:0]      rdata_q, rdata_d;

    logic             req;
    logic             accept;
    logic             resp_entry;
    logic             arr_we;
    mem_err_e         req_err;
    logic [31:0]      arr_rdata;

    assign req     = mem.data_memory_read | mem.data_memory_write;
    assign req_err = classify_req(mem.data_memory_read, mem.data_memory_write,
                                  mem.data_memory_a, DEPTH);
    assign accept  = (state_q == ST_IDLE) && !halt_f && req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clk_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (halt_f) begin
                        state_d = ST_HALTED;
                    end else if (req) begin
                        state_d = (req_err != MEM_ERR_OK || WAIT_CYCLES == 0) ? ST_RESP : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // A dropped request aborts even on the final wait cycle.
                    if (!req) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_d = (halt_f || halt_pend_q) ? ST_HALTED : ST_IDLE;
                end
                default: begin
                    state_d = ST_HALTED;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        is_write_d  = is_write_q;
        status_d    = status_q;
        halt_pend_d = halt_pend_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d       = '0;
                    addr_d      = mem.data_memory_a[AW+1:2];
                    is_write_d  = mem.data_memory_write;
                    status_d    = req_err;
                    halt_pend_d = 1'b0;
                end
            end
            ST_BUSY: begin
                cnt_d       = cnt_q + 1'b1;
                halt_pend_d = halt_pend_q | halt_f;
            end
            ST_RESP: begin
                halt_pend_d = halt_pend_q | halt_f;
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Read data is captured on the edge that enters RESP; addr_d covers the
    // zero-wait case where the address has not been latched yet.
    assign resp_entry = (state_d == ST_RESP) && (state_q != ST_RESP);
    assign rdata_d    = (resp_entry && status_d == MEM_ERR_OK && !is_write_d) ? arr_rdata : rdata_q;
    assign arr_we     = clk_en && (state_q == ST_RESP) && is_write_q && (status_q == MEM_ERR_OK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            addr_q      <= '0;
            is_write_q  <= 1'b0;
            status_q    <= MEM_ERR_OK;
            halt_pend_q <= 1'b0;
            rdata_q     <= '0;
        end else if (clk_en) begin
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            is_write_q  <= is_write_d;
            status_q    <= status_d;
            halt_pend_q <= halt_pend_d;
            rdata_q     <= rdata_d;
        end
    end

    scc_dmem_responder_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .waddr_i (addr_q),
        .wdata_i (mem.data_memory_out_v),
        .raddr_i (addr_d),
        .rdata_o (arr_rdata)
    );

    always_comb begin
        mem.mem_ready        = (state_q == ST_RESP);
        mem.mem_err          = (state_q == ST_RESP) ? status_q : MEM_ERR_OK;
        mem.data_memory_in_v = rdata_q;
    end

endmodule

// File: tb/tb_scc_dmem_responder.sv
// Scoreboard bench for scc_dmem_responder: a driver pushes expected responses
// computed from a word-array model, a negedge monitor pops and compares them.
module tb_scc_dmem_responder;

    localparam int DEPTH       = 256;
    localparam int WAIT_CYCLES = 2;

    typedef struct {
        int          id;
        int          exp_edge;
        logic [1:0]  err;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic clk_en;
    logic halt_f;

    scc_dmem_responder_if bus ();

    scc_dmem_responder #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .halt_f (halt_f),
        .mem    (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          en_cnt = 0;
    int          txn_id = 0;
    exp_t        sb_q[$];
    exp_t        mon_item;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] last_read = 32'h0;

    always @(posedge clk) if (clk_en) en_cnt <= en_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] model_err(input logic rd, input logic wr, input logic [31:0] addr);
        if (rd && wr) return 2'd1;
        if (addr % 4 != 0) return 2'd2;
        if (addr / 4 >= DEPTH) return 2'd3;
        return 2'd0;
    endfunction

    // Monitor: one response per enabled ready cycle.
    always @(negedge clk) begin
        if (!rst && bus.mem_ready && clk_en) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_ready", 32'(bus.mem_ready), 32'd0);
            end else begin
                mon_item = sb_q.pop_front();
                $display("txn %0d: err=%0d in_v=%h at enabled edge %0d", mon_item.id,
                         bus.mem_err, bus.data_memory_in_v, en_cnt);
                chk("mem_err", 32'(bus.mem_err), 32'(mon_item.err));
                chk("in_v", bus.data_memory_in_v, mon_item.data);
                chk("latency_edge", 32'(en_cnt), 32'(mon_item.exp_edge));
            end
        end
    end

    task automatic drop_req();
        bus.data_memory_read  = 1'b0;
        bus.data_memory_write = 1'b0;
    endtask

    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit rand_en,
                           input int stall_len, input int halt_at);
        exp_t       it;
        logic [1:0] e;
        int         raw;
        int         lat;
        int         idx;
        bit         got;
        bit         accepted;
        e   = model_err(rd, wr, addr);
        idx = int'(addr >> 2);
        lat = (e != 2'd0) ? 1 : WAIT_CYCLES + 1;
        bus.data_memory_a     = addr;
        bus.data_memory_read  = rd;
        bus.data_memory_write = wr;
        bus.data_memory_out_v = wdata;
        clk_en = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (e == 2'd0 && wr) model_mem[idx] = wdata;
        else if (e == 2'd0 && rd) last_read = model_mem[idx];
        it.id       = txn_id;
        it.exp_edge = en_cnt + lat;
        it.err      = e;
        it.data     = last_read;
        txn_id++;
        sb_q.push_back(it);
        raw = 0;
        got = 0;
        accepted = 0;
        while (!got && raw < 200) begin
            @(negedge clk);
            if (bus.mem_ready && clk_en) got = 1;
            @(posedge clk);
            #1;
            raw++;
            if (clk_en) accepted = 1;
            halt_f = (raw == halt_at);
            if (got) begin
                drop_req();
                clk_en = 1'b1;
            end else begin
                if (rand_en) clk_en = ($urandom_range(0, 3) != 0);
                else clk_en = !(raw >= 1 && raw <= stall_len);
                // Address wiggles after acceptance must not matter.
                if (rand_en && accepted) bus.data_memory_a = $urandom();
            end
        end
        halt_f = 1'b0;
        if (!got) begin
            chk("ready_timeout", 32'(got), 32'd1);
            drop_req();
            clk_en = 1'b1;
            void'(sb_q.pop_back());
        end else if (stall_len > 0) begin
            chk("stall_latency", 32'(raw), 32'(lat + 1 + stall_len));
        end
    endtask

    initial begin
        int          saw;
        logic [31:0] hv;
        rst    = 1'b1;
        clk_en = 1'b1;
        halt_f = 1'b0;
        bus.data_memory_a     = 32'h0;
        bus.data_memory_out_v = 32'h0;
        drop_req();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_ready", 32'(bus.mem_ready), 32'd0);
        chk("reset_err", 32'(bus.mem_err), 32'd0);
        chk("reset_in_v", bus.data_memory_in_v, 32'h0);

        for (int i = 0; i < 32; i++) run_txn(1'b0, 1'b1, 32'(i * 4), $urandom() | 32'h1, 1'b0, 0, -1);

        run_txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 0, -1);
        run_txn(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 0, -1);
        run_txn(1'b1, 1'b1, 32'h0, 32'h0, 1'b0, 0, -1);
        run_txn(1'b1, 1'b0, 32'h6, 32'h0, 1'b0, 0, -1);
        run_txn(1'b1, 1'b0, 32'h400, 32'h0, 1'b0, 0, -1);
        run_txn(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 5, -1);

        // Write to 0x20 abandoned mid-wait; the old word must survive.
        bus.data_memory_a     = 32'h20;
        bus.data_memory_out_v = 32'h0BADF00D;
        bus.data_memory_write = 1'b1;
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        drop_req();
        repeat (4) @(posedge clk);
        #1;
        run_txn(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 0, -1);

        for (int n = 0; n < 80; n++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            a    = 32'($urandom_range(0, 31)) << 2;
            if (kind <= 3) run_txn(1'b0, 1'b1, a, $urandom(), 1'b1, 0, -1);
            else if (kind <= 7) run_txn(1'b1, 1'b0, a, 32'h0, 1'b1, 0, -1);
            else if (kind == 8) run_txn(1'b1, 1'b1, a, $urandom(), 1'b1, 0, -1);
            else if ($urandom_range(0, 1) == 0) run_txn(1'b1, 1'b0, a | 32'($urandom_range(1, 3)), 32'h0, 1'b1, 0, -1);
            else run_txn(1'b0, 1'b1, 32'($urandom_range(DEPTH, 32'h3FFFFFFF)) << 2, $urandom(), 1'b1, 0, -1);
        end

        // Halt pulsed while a write waits: it completes, then nothing is served.
        hv = $urandom() | 32'h1;
        run_txn(1'b0, 1'b1, 32'h24, hv, 1'b0, 0, 2);
        bus.data_memory_a    = 32'h24;
        bus.data_memory_read = 1'b1;
        saw = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.mem_ready) saw++;
        end
        chk("halted_no_ready", 32'(saw), 32'd0);
        drop_req();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_read = 32'h0;
        run_txn(1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 0, -1);

        // Reset asserted between edges while a read is waiting.
        bus.data_memory_a    = 32'hC;
        bus.data_memory_read = 1'b1;
        clk_en = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midbusy_rst_ready", 32'(bus.mem_ready), 32'd0);
        chk("midbusy_rst_err", 32'(bus.mem_err), 32'd0);
        chk("midbusy_rst_in_v", bus.data_memory_in_v, 32'h0);
        drop_req();
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_read = 32'h0;
        run_txn(1'b1, 1'b0, 32'hC, 32'h0, 1'b0, 0, -1);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, required finish before 1000000 time units");
        $fatal(1);
    end

endmodule
